// File: rtl/cla_iter_pkg.sv
// Shared types and size helpers for the nibble-serial carry-lookahead adder.
package cla_iter_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_nib(input int width);
        return width / NIB_W;
    endfunction

    function automatic int calc_cw(input int nib);
        return (nib <= 1) ? 1 : $clog2(nib);
    endfunction

endpackage

// File: rtl/cla4_slice.sv
// 4-bit carry-lookahead slice; every carry is a flat sum of generate/propagate products.
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       c3,
    output logic       c4
);

    logic [3:0] g_s;
    logic [3:0] p_s;
    logic       c1_s;
    logic       c2_s;

    assign g_s = a & b;
    assign p_s = a ^ b;

    assign c1_s = g_s[0] | (p_s[0] & cin);
    assign c2_s = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
    assign c3   = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                | (p_s[2] & p_s[1] & p_s[0] & cin);
    assign c4   = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & cin);

    assign s = p_s ^ {c3, c2_s, c1_s, cin};

endmodule

// File: rtl/cla_iter_adder_ctrl.sv
// Low-area WIDTH-bit add/subtract: one CLA slice reused LSB-first, one nibble per cycle.
module cla_iter_adder_ctrl
    import cla_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             busy
);

    localparam int NIB = calc_nib(WIDTH);
    localparam int CW  = calc_cw(NIB);
    localparam logic [CW-1:0] LAST_IDX = CW'(NIB - 1);

    state_t           state_r;
    logic [CW-1:0]    cnt_r;
    logic             carry_r;
    logic [WIDTH-1:0] op_a_r;
    logic [WIDTH-1:0] op_b_r;
    logic [WIDTH-1:0] result_r;
    logic             cout_r;
    logic             ovf_r;
    logic             zero_r;
    logic             out_valid_r;
    logic             busy_r;

    logic [CW+1:0]    base_s;
    logic [3:0]       nib_a_s;
    logic [3:0]       nib_b_s;
    logic [3:0]       nib_sum_s;
    logic             c3_s;
    logic             c4_s;
    logic [WIDTH-1:0] result_next_s;

    // Select the active nibble and merge its sum into the running result.
    always_comb begin
        base_s        = {cnt_r, 2'b00};
        nib_a_s       = op_a_r[base_s +: NIB_W];
        nib_b_s       = op_b_r[base_s +: NIB_W];
        result_next_s = result_r;
        result_next_s[base_s +: NIB_W] = nib_sum_s;
    end

    cla4_slice u_slice (
        .a   (nib_a_s),
        .b   (nib_b_s),
        .cin (carry_r),
        .s   (nib_sum_s),
        .c3  (c3_s),
        .c4  (c4_s)
    );

    // Sequencer: accept, iterate nibbles, hold result until consumed; flush aborts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            carry_r     <= 1'b0;
            op_a_r      <= '0;
            op_b_r      <= '0;
            result_r    <= '0;
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            zero_r      <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else if (flush) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            carry_r     <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        op_a_r  <= a;
                        op_b_r  <= sub ? ~b : b;
                        carry_r <= sub ? 1'b1 : cin;
                        cnt_r   <= '0;
                        state_r <= RUN;
                        busy_r  <= 1'b1;
                    end
                end
                RUN: begin
                    result_r <= result_next_s;
                    carry_r  <= c4_s;
                    if (cnt_r == LAST_IDX) begin
                        // c3 of the top nibble is the carry into the MSB.
                        cout_r      <= c4_s;
                        ovf_r       <= c3_s ^ c4_s;
                        zero_r      <= (result_next_s == {WIDTH{1'b0}});
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= '0;
                    carry_r     <= 1'b0;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == IDLE) & ~flush;
    assign out_valid = out_valid_r;
    assign sum       = result_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;
    assign zero      = zero_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_cla_iter_adder_ctrl.sv
// Randomized self-checking bench for cla_iter_adder_ctrl against a plain-arithmetic model.
module tb_cla_iter_adder_ctrl;

    localparam int WIDTH = 32;
    localparam int NIB   = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             sub = 1'b0;
    logic             cin = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             busy;

    int n_total = 0;
    int n_bad   = 0;

    cla_iter_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: {zero, ovf, cout, sum} from ordinary wide integer arithmetic.
    function automatic logic [WIDTH+2:0] model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                               input logic msub, input logic mcin);
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] bb;
        logic [WIDTH-1:0] s;
        logic             ci;
        logic             v;
        bb   = msub ? ~mb : mb;
        ci   = msub ? 1'b1 : mcin;
        full = {1'b0, ma} + {1'b0, bb} + {{WIDTH{1'b0}}, ci};
        s    = full[WIDTH-1:0];
        v    = (ma[WIDTH-1] == bb[WIDTH-1]) && (s[WIDTH-1] != ma[WIDTH-1]);
        return {(s == '0), v, full[WIDTH], s};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                            input logic tsub, input logic tcin);
        check_eq("in_ready_idle", 64'(in_ready), 64'd1);
        a = ta; b = tb; sub = tsub; cin = tcin;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = $urandom; b = $urandom;
        check_eq("busy_after_accept", 64'(busy), 64'd1);
    endtask

    task automatic wait_done();
        int cyc = 0;
        while (out_valid !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        check_eq("latency", 64'(cyc), 64'(NIB));
    endtask

    task automatic check_res(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                             input logic tsub, input logic tcin);
        logic [WIDTH+2:0] m;
        m = model(ta, tb, tsub, tcin);
        check_eq("sum",  64'(sum),  64'(m[WIDTH-1:0]));
        check_eq("cout", 64'(cout), 64'(m[WIDTH]));
        check_eq("ovf",  64'(ovf),  64'(m[WIDTH+1]));
        check_eq("zero", 64'(zero), 64'(m[WIDTH+2]));
    endtask

    task automatic release_res();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("out_valid_drop", 64'(out_valid), 64'd0);
        check_eq("busy_drop", 64'(busy), 64'd0);
    endtask

    task automatic full_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                           input logic tsub, input logic tcin, input int hold);
        start_op(ta, tb, tsub, tcin);
        wait_done();
        repeat (hold) tick();
        check_res(ta, tb, tsub, tcin);
        release_res();
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb, na, nb;
        logic             rs, rc;
        logic [WIDTH-1:0] corner [0:5];
        int               cyc;
        corner[0] = 32'h0000_0000; corner[1] = 32'hFFFF_FFFF; corner[2] = 32'h7FFF_FFFF;
        corner[3] = 32'h8000_0000; corner[4] = 32'h0000_0001; corner[5] = 32'h0F0F_F0F0;

        #3;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_sum", 64'(sum), 64'd0);
        check_eq("rst_flags", 64'({cout, ovf, zero}), 64'd0);
        #9 rst_n = 1'b1;
        tick();

        full_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
        full_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1);
        full_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 0);
        full_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 0);
        full_op(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0, 2);

        // Backpressure with a new request waiting.
        start_op(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b1);
        wait_done();
        na = 32'hDEAD_BEEF; nb = 32'h1111_1111;
        a = na; b = nb; sub = 1'b1; cin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("bp_in_ready", 64'(in_ready), 64'd0);
            check_eq("bp_out_valid", 64'(out_valid), 64'd1);
            check_res(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("bp_release_valid", 64'(out_valid), 64'd0);
        check_eq("bp_release_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check_eq("bp_accept", 64'(busy), 64'd1);
        wait_done();
        check_res(na, nb, 1'b1, 1'b0);
        release_res();

        // Flush at counter 3 while another request is offered.
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        repeat (3) tick();
        flush = 1'b1; in_valid = 1'b1; a = 32'h5555_5555; b = 32'h2222_2222; sub = 1'b0; cin = 1'b0;
        check_eq("flush_in_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check_eq("flush_busy", 64'(busy), 64'd0);
        check_eq("flush_out_valid", 64'(out_valid), 64'd0);
        cyc = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid !== 1'b0 || busy !== 1'b0) cyc++;
        end
        check_eq("flush_quiet", 64'(cyc), 64'd0);
        full_op(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 0);

        // Asynchronous reset in the middle of RUN.
        start_op(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b1);
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_out_valid", 64'(out_valid), 64'd0);
        check_eq("arst_busy", 64'(busy), 64'd0);
        check_eq("arst_sum", 64'(sum), 64'd0);
        check_eq("arst_flags", 64'({cout, ovf, zero}), 64'd0);
        #3 rst_n = 1'b1;
        tick();
        full_op(32'h0000_000F, 32'h0000_0001, 1'b0, 1'b1, 0);

        // Randomized operations, mixing in corner operands.
        for (int k = 0; k < 30; k++) begin
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            full_op(ra, rb, rs, rc, int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
